// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encodings and default width.
package serial_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'b00;
    localparam state_t SHIFT = 2'b01;
    localparam state_t DONE  = 2'b10;

    // The unused encoding behaves exactly like IDLE.
    function automatic state_t decode_state(input state_t s);
        return ((s == SHIFT) || (s == DONE)) ? s : IDLE;
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Start/busy/done handshake plus operand and result buses of the serial adder.
interface serial_adder_ctrl_if
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum_out;
    logic             cout;

    modport master (
        output start, a_in, b_in, cin,
        input  busy, done, sum_out, cout
    );

    modport slave (
        input  start, a_in, b_in, cin,
        output busy, done, sum_out, cout
    );

endinterface

// File: rtl/full_adder.sv
// One-bit full adder cell; the only arithmetic element of the serial datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: time-multiplexes one full_adder over WIDTH-bit operands,
// LSB first, with a start/busy/done handshake.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input logic               clk,
    input logic               rst,
    serial_adder_ctrl_if.slave bus
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    state_t           state;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] sum_sh_q;
    logic [WIDTH-1:0] sum_shifted;
    logic [WIDTH-1:0] sum_out_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             cout_q;
    logic             fa_sum;
    logic             fa_carry;
    logic             accept;
    logic             last;

    assign state = decode_state(state_q);

    full_adder u_full_adder (
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .c     (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    assign sum_shifted = {fa_sum, sum_sh_q[WIDTH-1:1]};
    assign accept      = (state == IDLE) && bus.start;
    assign last        = (state == SHIFT) && (cnt_q == LAST_BIT);

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (bus.start) state_d = SHIFT;
            SHIFT:   if (cnt_q == LAST_BIT) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            sum_sh_q  <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            sum_out_q <= '0;
            cout_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_sh_q   <= bus.a_in;
                b_sh_q   <= bus.b_in;
                carry_q  <= bus.cin;
                cnt_q    <= '0;
                sum_sh_q <= '0;
            end else if (state == SHIFT) begin
                a_sh_q   <= a_sh_q >> 1;
                b_sh_q   <= b_sh_q >> 1;
                sum_sh_q <= sum_shifted;
                carry_q  <= fa_carry;
                cnt_q    <= cnt_q + CNT_W'(1);
                // Result registers change only when the last bit lands.
                if (last) begin
                    sum_out_q <= sum_shifted;
                    cout_q    <= fa_carry;
                end
            end
        end
    end

    assign bus.busy    = (state != IDLE);
    assign bus.done    = (state == DONE);
    assign bus.sum_out = sum_out_q;
    assign bus.cout    = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: WIDTH=8 directed/random traffic and WIDTH=2 exhaustive.
module tb_serial_adder_ctrl;
    import serial_adder_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned W2 = 2;

    typedef struct {
        int res;
        int at;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder_ctrl_if #(.WIDTH(W))  bus8 ();
    serial_adder_ctrl_if #(.WIDTH(W2)) bus2 ();

    serial_adder_ctrl #(.WIDTH(W)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    serial_adder_ctrl #(.WIDTH(W2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    int   checks = 0;
    int   errors = 0;
    // Reference model: window of busy cycles of the latest accepted addition.
    int   free_at = 0;
    int   busy_lo = 0;
    int   busy_hi = -1;
    int   n_acc = 0;
    int   held = 0;
    exp_t q8[$];
    int   done_cyc8[$];
    int   q2[$];
    int   n_pop2 = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    // Drives one cycle of WIDTH=8 stimulus and lets the model decide whether it is accepted.
    task automatic cycle8(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci);
        exp_t e;
        bus8.start = s;
        bus8.a_in  = a;
        bus8.b_in  = b;
        bus8.cin   = ci;
        if (!rst && s && cyc >= free_at) begin
            e.res = int'(a) + int'(b) + int'(ci);
            e.at  = cyc + 1 + int'(W);
            q8.push_back(e);
            busy_lo = cyc + 1;
            busy_hi = cyc + 1 + int'(W);
            free_at = cyc + 2 + int'(W);
            n_acc++;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic wait_free8();
        while (cyc < free_at) cycle8(1'b0, W'($urandom), W'($urandom), 1'($urandom));
    endtask

    initial begin : monitor8
        exp_t e;
        forever begin
            @(negedge clk);
            check("busy8", bus8.busy, (cyc >= busy_lo && cyc <= busy_hi));
            check("done8", bus8.done, (cyc == busy_hi));
            if (bus8.done) begin
                done_cyc8.push_back(cyc);
                if (q8.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done8 cycle %0d: got done=1 expected none", cyc);
                end else begin
                    e = q8.pop_front();
                    check("done_cycle8", cyc, e.at);
                    held = e.res;
                end
            end
            check("result8", {bus8.cout, bus8.sum_out}, held);
        end
    end

    initial begin : monitor2
        int r;
        forever begin
            @(negedge clk);
            if (bus2.done) begin
                if (q2.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done2 cycle %0d: got done=1 expected none", cyc);
                end else begin
                    r = q2.pop_front();
                    check("result2", {bus2.cout, bus2.sum_out}, r);
                    n_pop2++;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no end of run, expected finish");
        $fatal(1);
    end

    initial begin : driver
        int target;
        int n;
        logic [W2-1:0] a2;
        logic [W2-1:0] b2;
        logic          c2;
        logic [4:0]    v5;
        bus8.start = 1'b0;
        bus8.a_in  = '0;
        bus8.b_in  = '0;
        bus8.cin   = 1'b0;
        bus2.start = 1'b0;
        bus2.a_in  = '0;
        bus2.b_in  = '0;
        bus2.cin   = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;

        cycle8(1'b1, 8'h5A, 8'h3C, 1'b0);
        wait_free8();
        cycle8(1'b1, 8'hFF, 8'h01, 1'b0);
        wait_free8();
        cycle8(1'b1, 8'hFF, 8'hFF, 1'b1);
        wait_free8();

        // Start and operand changes while busy must be ignored.
        cycle8(1'b1, 8'h33, 8'h44, 1'b0);
        cycle8(1'b1, 8'h11, 8'h22, 1'b0);
        for (int i = 0; i < int'(W); i++) cycle8(1'b1, W'($urandom), W'($urandom), 1'($urandom));
        wait_free8();

        // Abort in the 4th SHIFT cycle.
        cycle8(1'b1, 8'h0F, 8'h01, 1'b0);
        repeat (3) cycle8(1'b0, 8'h00, 8'h00, 1'b0);
        rst = 1'b1;
        q8.delete();
        busy_lo = 0;
        busy_hi = -1;
        free_at = 0;
        held    = 0;
        #1;
        check("rst_busy8", bus8.busy, 1'b0);
        check("rst_result8", {bus8.cout, bus8.sum_out}, 0);
        cycle8(1'b0, 8'h00, 8'h00, 1'b0);
        cycle8(1'b1, 8'h0F, 8'h01, 1'b0);
        rst = 1'b0;
        cycle8(1'b1, 8'h0F, 8'h01, 1'b0);
        wait_free8();

        repeat (60) cycle8($urandom_range(0, 2) == 0, W'($urandom), W'($urandom), 1'($urandom));
        wait_free8();

        target = n_acc + 3;
        while (n_acc < target) cycle8(1'b1, W'($urandom), W'($urandom), 1'($urandom));
        wait_free8();
        repeat (2) cycle8(1'b0, 8'h00, 8'h00, 1'b0);
        n = done_cyc8.size();
        check("done_count8", (n >= 3), 1'b1);
        if (n >= 3) begin
            check("spacing8_a", done_cyc8[n-1] - done_cyc8[n-2], W + 2);
            check("spacing8_b", done_cyc8[n-2] - done_cyc8[n-3], W + 2);
        end
        check("q8_empty", q8.size(), 0);

        // WIDTH=2 exhaustive sweep of a, b, cin.
        for (int v = 0; v < 32; v++) begin
            v5 = 5'(v);
            a2 = v5[1:0];
            b2 = v5[3:2];
            c2 = v5[4];
            bus2.start = 1'b1;
            bus2.a_in  = a2;
            bus2.b_in  = b2;
            bus2.cin   = c2;
            q2.push_back(int'(a2) + int'(b2) + int'(c2));
            @(negedge clk);
            #1;
            bus2.start = 1'b0;
            bus2.a_in  = 2'($urandom);
            bus2.b_in  = 2'($urandom);
            repeat (3) begin
                @(negedge clk);
                #1;
            end
        end
        repeat (2) @(negedge clk);
        #1;
        check("pops2", n_pop2, 32);
        check("q2_empty", q2.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder controller: one shared full_adder cell is time-multiplexed over WIDTH-bit operands, LSB first, one bit per clock.
- A carry flip-flop chains the bits.
- Uses a start/busy/done handshake so upstream logic can issue multi-bit additions on the single 1-bit adder datapath.
- Sits between an operand source (register file or test sequencer) and the full_adder cell.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH)+1, bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a_in  input  WIDTH  operand A; captured on the accepting edge.
- b_in  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high while in SHIFT or DONE.
- done  output  1  single-cycle pulse; result valid.
- sum_out  output  WIDTH  result; held stable from done until the next accepted start.
- cout  output  1  final carry-out; held like sum_out.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, busy=0, done=0, sum_out=0, cout=0, operand shift registers=0, carry FF=0, bit counter=0.
- States:
  - IDLE -> SHIFT on an edge with start=1. That edge loads: a_sh<=a_in, b_sh<=b_in, carry<=cin, cnt<=0, sum_sh<=0.
  - SHIFT: each edge drives the full_adder with a=a_sh[0], b=b_sh[0], c=carry.
    - sum_sh<={fa_sum, sum_sh[WIDTH-1:1]}; carry<=fa_carry; a_sh, b_sh shift right by 1; cnt<=cnt+1.
    - On the edge where cnt==WIDTH-1: state->DONE, sum_out<=final sum_sh value, cout<=fa_carry.
  - DONE: done=1 for exactly this one cycle; next edge -> IDLE unconditionally.
- Latency: start accepted at edge E0; done high in the cycle after edge E0+WIDTH. Next start is accepted at the edge ending the DONE cycle +1, i.e. first IDLE cycle. Throughput is one addition per WIDTH+2 cycles.
- busy is combinational from state: (state!=IDLE).
- done is combinational from state: (state==DONE).
- start while busy (SHIFT or DONE): ignored, no effect on operands or result.
- a_in, b_in, cin are don't-care except on the accepting edge.
- sum_out and cout update only on the transition into DONE. Intermediate partial sums are never visible on sum_out.
- Arithmetic: {cout,sum_out} == a_in + b_in + cin, modulo 2^(WIDTH+1); no overflow flag.
- Reset mid-operation: immediate abort to reset values. No done pulse. A new start after reset release proceeds normally.
- start high continuously: a new addition starts on each first IDLE edge, so done pulses every WIDTH+2 cycles.
- Illegal state encodings decode to IDLE.

Decomposition:
- Shared package serial_adder_pkg: state enum (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10) and the WIDTH default constant.
- One sub-module instance: full_adder (ports a, b, c, sum, carry), the existing 1-bit cell, instantiated once as the datapath. No other sub-modules.
- FSM, shift registers and counter live in serial_adder_ctrl.

Test Plan (WIDTH=8 unless noted):
- Reset, then start with a_in=0x5A, b_in=0x3C, cin=0 -> done pulse 9 cycles after the start edge; sum_out=0x96, cout=0; busy high for exactly 9 cycles.
- a_in=0xFF, b_in=0x01, cin=0 -> sum_out=0x00, cout=1. Then a_in=0xFF, b_in=0xFF, cin=1 -> sum_out=0xFF, cout=1.
- During SHIFT, pulse start with a_in=0x11, b_in=0x22 -> ignored; result is still that of the first operands. Operands changing after acceptance must not alter the result.
- Assert rst at the 4th SHIFT cycle of a 0x0F+0x01 operation -> outputs 0 immediately and no done pulse. Afterwards 0x0F+0x01 -> sum_out=0x10, cout=0.
- start held high for 3 operations -> done pulses exactly 10 cycles apart. sum_out is stable between pulses.
- WIDTH=2: exhaustive over all 32 (a, b, cin) combinations -> {cout,sum_out} equals a+b+cin every time.
